// File: rtl/bin2bcd_dabble.sv
// Sequential shift-and-add-3 binary-to-BCD converter, 2*W cycles from accepted start to the one-cycle DONE pulse.
// Optional truncation detection is built only when BCD_OVF_EN is defined; otherwise out_ovf is tied low.
module bin2bcd_dabble #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_init,
    input  logic [W-1:0]          in_bin,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_busy,
    output logic                  out_DONE,
    output logic                  out_ovf
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    bin_q, bin_d;
    logic [BW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   out_bcd_q, out_bcd_d;
    logic [BW-1:0]   acc_adj;
    logic [BW+W-1:0] work_sh;

`ifdef BCD_OVF_EN
    logic            ovf_acc_q, ovf_acc_d;
    logic            out_ovf_q, out_ovf_d;
    logic            shift_ovf;
`endif

    // Every digit is corrected independently; a digit never exceeds 9 here, so +3 cannot wrap.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign work_sh = {acc_q, bin_q} << 1;

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_bcd_d = out_bcd_q;
`ifdef BCD_OVF_EN
        ovf_acc_d = ovf_acc_q;
        out_ovf_d = out_ovf_q;
        shift_ovf = ovf_acc_q | acc_q[BW-1];
`endif
        case (state_q)
            IDLE: begin
                if (in_init) begin
                    bin_d   = in_bin;
                    acc_d   = '0;
                    cnt_d   = CW'(W);
`ifdef BCD_OVF_EN
                    ovf_acc_d = 1'b0;
`endif
                    state_d = ADJUST;
                end
            end
            ADJUST: begin
                acc_d   = acc_adj;
`ifdef BCD_OVF_EN
                // A top digit of 8 or more is guaranteed to carry out on the next shift.
                if (acc_adj[BW-1 -: 4] >= 4'd8) begin
                    ovf_acc_d = 1'b1;
                end
`endif
                state_d = SHIFT;
            end
            SHIFT: begin
                acc_d = work_sh[W +: BW];
                bin_d = work_sh[W-1:0];
                cnt_d = cnt_q - CW'(1);
`ifdef BCD_OVF_EN
                ovf_acc_d = shift_ovf;
`endif
                if (cnt_q == CW'(1)) begin
                    out_bcd_d = work_sh[W +: BW];
`ifdef BCD_OVF_EN
                    out_ovf_d = shift_ovf;
`endif
                    state_d   = DONE;
                end else begin
                    state_d   = ADJUST;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_bcd_q <= '0;
`ifdef BCD_OVF_EN
            ovf_acc_q <= 1'b0;
            out_ovf_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_bcd_q <= out_bcd_d;
`ifdef BCD_OVF_EN
            ovf_acc_q <= ovf_acc_d;
            out_ovf_q <= out_ovf_d;
`endif
        end
    end

    assign out_bcd  = out_bcd_q;
    assign out_busy = (state_q == ADJUST) || (state_q == SHIFT);
    assign out_DONE = (state_q == DONE);
`ifdef BCD_OVF_EN
    assign out_ovf  = out_ovf_q;
`else
    assign out_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_dabble.sv
// Bench for bin2bcd_dabble: three instances (8b/3 digits, 8b/2 digits truncating, 16b/5 digits)
// compared against an arithmetic decimal model.
module tb_bin2bcd_dabble;

    logic        clk;
    logic        rst;
    logic        init8, init16;
    logic [7:0]  bin8;
    logic [15:0] bin16;

    logic [11:0] bcd_a;
    logic        busy_a, done_a, ovf_a;
    logic [7:0]  bcd_c;
    logic        busy_c, done_c, ovf_c;
    logic [19:0] bcd_b;
    logic        busy_b, done_b, ovf_b;

    int checks = 0;
    int errors = 0;

    logic [63:0] prev_a, prev_b, prev_c;

    bin2bcd_dabble #(.W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst), .in_init(init8), .in_bin(bin8),
        .out_bcd(bcd_a), .out_busy(busy_a), .out_DONE(done_a), .out_ovf(ovf_a)
    );

    bin2bcd_dabble #(.W(8), .DIGITS(2)) dut_c (
        .clk(clk), .rst(rst), .in_init(init8), .in_bin(bin8),
        .out_bcd(bcd_c), .out_busy(busy_c), .out_DONE(done_c), .out_ovf(ovf_c)
    );

    bin2bcd_dabble #(.W(16), .DIGITS(5)) dut_b (
        .clk(clk), .rst(rst), .in_init(init16), .in_bin(bin16),
        .out_bcd(bcd_b), .out_busy(busy_b), .out_DONE(done_b), .out_ovf(ovf_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, lowest d digits only, packed 4 bits each.
    function automatic logic [63:0] to_bcd(input longint v, input int d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input longint v, input int d);
        longint lim;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
`ifdef BCD_OVF_EN
        return v >= lim;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the DONE cycle.
    task automatic conv8(input logic [7:0] v, input bit noise);
        int cyc, bsy;
        bin8 = v;
        init8 = 1'b1;
        @(negedge clk);
        init8 = 1'b0;
        cyc = 0;
        bsy = 0;
        while (!done_a && cyc < 40) begin
            if (busy_a) bsy++;
            if (cyc == 5) check("hold_a", bcd_a, prev_a);
            if (noise) begin
                init8 = 1'($urandom_range(0, 1));
                bin8  = 8'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        init8 = 1'b0;
        check("lat8", cyc, 16);
        check("busy8", bsy, 16);
        check("bcd_a", bcd_a, to_bcd(v, 3));
        check("ovf_a", ovf_a, 0);
        check("bcd_c", bcd_c, to_bcd(v, 2));
        check("ovf_c", ovf_c, model_ovf(v, 2));
        check("done_c", done_c, 1);
        check("busy_in_done", busy_a, 0);
        @(negedge clk);
        check("pulse8", done_a, 0);
        prev_a = to_bcd(v, 3);
        prev_c = to_bcd(v, 2);
    endtask

    task automatic conv16(input logic [15:0] v);
        int cyc, bsy;
        bin16 = v;
        init16 = 1'b1;
        @(negedge clk);
        init16 = 1'b0;
        cyc = 0;
        bsy = 0;
        while (!done_b && cyc < 80) begin
            if (busy_b) bsy++;
            if (cyc == 9) check("hold_b", bcd_b, prev_b);
            @(negedge clk);
            cyc++;
        end
        check("lat16", cyc, 32);
        check("busy16", bsy, 32);
        check("bcd_b", bcd_b, to_bcd(v, 5));
        check("ovf_b", ovf_b, 0);
        @(negedge clk);
        check("pulse16", done_b, 0);
        prev_b = to_bcd(v, 5);
    endtask

    initial begin
        int k, last, ndone;
        clk = 1'b0;
        rst = 1'b1;
        init8 = 1'b0;
        init16 = 1'b0;
        bin8 = '0;
        bin16 = '0;
        prev_a = '0;
        prev_b = '0;
        prev_c = '0;
        repeat (3) @(negedge clk);
        check("rst_bcd_a", bcd_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_ovf_c", ovf_c, 0);
        check("rst_bcd_b", bcd_b, 0);
        rst = 1'b0;
        @(negedge clk);

        conv8(8'd255, 1'b0);
        conv8(8'd0, 1'b0);
        conv8(8'd99, 1'b0);
        conv8(8'd100, 1'b1);

        // Held start request: one conversion every 18 cycles, result stable.
        bin8 = 8'd37;
        init8 = 1'b1;
        last = -1;
        ndone = 0;
        for (k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done_a) begin
                ndone++;
                if (last >= 0) check("gap37", k - last, 18);
                last = k;
                check("bcd37", bcd_a, 12'h037);
            end
        end
        init8 = 1'b0;
        check("n37", ndone, 3);
        k = 0;
        while ((busy_a || done_a) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain37", busy_a | done_a, 0);
        prev_a = 64'h037;
        prev_c = 64'h37;

        // Reset in the middle of a conversion discards it.
        bin8 = 8'd200;
        init8 = 1'b1;
        @(negedge clk);
        init8 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", busy_a, 0);
        check("mrst_bcd", bcd_a, 0);
        check("mrst_done", done_a, 0);
        prev_a = '0;
        prev_b = '0;
        prev_c = '0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        check("mrst_nodone", ndone, 0);
        conv8(8'd200, 1'b0);

        // Reset and start on the same edge: start is lost.
        rst = 1'b1;
        init8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        init8 = 1'b0;
        check("rst_init_busy", busy_a, 0);
        prev_a = '0;
        prev_b = '0;
        prev_c = '0;
        @(negedge clk);

        repeat (20) conv8(8'($urandom), 1'($urandom_range(0, 1)));

        conv16(16'd65535);
        conv16(16'd0);
        repeat (6) conv16(16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
